// File: rtl/bp_me_pkg.sv
// Shared types and layout helpers for the DRAM hash translator.
// Field offsets are derived once here so every user agrees on layout.
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_hash_bypass   = 2'b00,
        e_hash_decode   = 2'b01,
        e_hash_encode   = 2'b10,
        e_hash_reserved = 2'b11
    } bp_dram_hash_mode_e;

    typedef enum logic [1:0] {
        e_fld_set,
        e_fld_cce,
        e_fld_slice,
        e_fld_bank
    } bp_dram_field_e;

    // Bit count of a field; a single-entry structure needs no bits.
    function automatic int lg_or_zero(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Offset of a field in the hashed (linear=0) or linear (linear=1) layout.
    function automatic int field_off(
        input bit             linear,
        input bp_dram_field_e fld,
        input int             blk_w,
        input int             set_w,
        input int             cce_w,
        input int             slice_w,
        input int             bank_w
    );
        int off;
        off = blk_w;
        if (linear) begin
            case (fld)
                e_fld_cce:   off = blk_w;
                e_fld_slice: off = blk_w + cce_w;
                e_fld_bank:  off = blk_w + cce_w + slice_w;
                default:     off = blk_w + cce_w + slice_w + bank_w;
            endcase
        end else begin
            case (fld)
                e_fld_set:   off = blk_w;
                e_fld_cce:   off = blk_w + set_w;
                e_fld_slice: off = blk_w + set_w + cce_w;
                default:     off = blk_w + set_w + cce_w + slice_w;
            endcase
        end
        return off;
    endfunction

endpackage

// File: rtl/bp_me_dram_hash_swizzle.sv
// Combinational hashed <-> linear address permutation.
// lin_o is always the linear-layout view used for channel selection.
module bp_me_dram_hash_swizzle
    import bp_me_pkg::*;
#(
    parameter int daddr_width_p    = 16,
    parameter int l2_block_width_p = 512,
    parameter int l2_sets_p        = 4,
    parameter int num_cce_p        = 2,
    parameter int l2_slices_p      = 2,
    parameter int l2_banks_p       = 2
) (
    input  logic [daddr_width_p-1:0] addr_i,
    input  logic [1:0]               mode_i,
    output logic [daddr_width_p-1:0] addr_o,
    output logic [daddr_width_p-1:0] lin_o
);

    localparam int BLK_W   = lg_or_zero(l2_block_width_p / 8);
    localparam int SET_W   = lg_or_zero(l2_sets_p);
    localparam int CCE_W   = lg_or_zero(num_cce_p);
    localparam int SLICE_W = lg_or_zero(l2_slices_p);
    localparam int BANK_W  = lg_or_zero(l2_banks_p);

    localparam int H_SET   = field_off(1'b0, e_fld_set,   BLK_W, SET_W, CCE_W, SLICE_W, BANK_W);
    localparam int H_CCE   = field_off(1'b0, e_fld_cce,   BLK_W, SET_W, CCE_W, SLICE_W, BANK_W);
    localparam int H_SLICE = field_off(1'b0, e_fld_slice, BLK_W, SET_W, CCE_W, SLICE_W, BANK_W);
    localparam int H_BANK  = field_off(1'b0, e_fld_bank,  BLK_W, SET_W, CCE_W, SLICE_W, BANK_W);
    localparam int L_SET   = field_off(1'b1, e_fld_set,   BLK_W, SET_W, CCE_W, SLICE_W, BANK_W);
    localparam int L_CCE   = field_off(1'b1, e_fld_cce,   BLK_W, SET_W, CCE_W, SLICE_W, BANK_W);
    localparam int L_SLICE = field_off(1'b1, e_fld_slice, BLK_W, SET_W, CCE_W, SLICE_W, BANK_W);
    localparam int L_BANK  = field_off(1'b1, e_fld_bank,  BLK_W, SET_W, CCE_W, SLICE_W, BANK_W);

    logic [daddr_width_p-1:0] dec;
    logic [daddr_width_p-1:0] enc;

    // Permute fields; block and tag bits keep their positions in both layouts.
    always_comb begin
        dec = addr_i;
        enc = addr_i;
        for (int i = 0; i < SET_W; i++) begin
            dec[L_SET+i] = addr_i[H_SET+i];
            enc[H_SET+i] = addr_i[L_SET+i];
        end
        for (int i = 0; i < CCE_W; i++) begin
            dec[L_CCE+i] = addr_i[H_CCE+i];
            enc[H_CCE+i] = addr_i[L_CCE+i];
        end
        for (int i = 0; i < SLICE_W; i++) begin
            dec[L_SLICE+i] = addr_i[H_SLICE+i];
            enc[H_SLICE+i] = addr_i[L_SLICE+i];
        end
        for (int i = 0; i < BANK_W; i++) begin
            dec[L_BANK+i] = addr_i[H_BANK+i];
            enc[H_BANK+i] = addr_i[L_BANK+i];
        end
    end

    // Select transform; reserved falls back to bypass.
    always_comb begin
        addr_o = addr_i;
        lin_o  = addr_i;
        case (bp_dram_hash_mode_e'(mode_i))
            e_hash_decode: begin
                addr_o = dec;
                lin_o  = dec;
            end
            e_hash_encode: begin
                addr_o = enc;
                lin_o  = addr_i;
            end
            default: begin
                addr_o = addr_i;
                lin_o  = addr_i;
            end
        endcase
    end

endmodule

// File: rtl/bp_me_dram_hash_xlate.sv
// Streaming DRAM address translator with channel select.
// Translation feeds a 2-entry FIFO; outputs come from its head.
module bp_me_dram_hash_xlate
    import bp_me_pkg::*;
#(
    parameter int daddr_width_p    = 16,
    parameter int l2_block_width_p = 512,
    parameter int l2_sets_p        = 4,
    parameter int num_cce_p        = 2,
    parameter int l2_slices_p      = 2,
    parameter int l2_banks_p       = 2,
    parameter int channels_p       = 2,
    parameter int xor_hash_p       = 0,
    parameter int tag_p            = 1,
    localparam int LG_CH = lg_or_zero(channels_p),
    localparam int CH_W  = (LG_CH == 0) ? 1 : LG_CH
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [daddr_width_p-1:0] addr_i,
    input  logic [1:0]               mode_i,
    input  logic [tag_p-1:0]         tag_i,
    input  logic                     v_i,
    output logic                     ready_and_o,
    output logic [daddr_width_p-1:0] addr_o,
    output logic [CH_W-1:0]          channel_o,
    output logic [tag_p-1:0]         tag_o,
    output logic                     v_o,
    input  logic                     ready_and_i,
    output logic                     err_o,
    output logic [31:0]              count_o
);

    localparam int BLK_W   = lg_or_zero(l2_block_width_p / 8);
    localparam int TAG_OFF = BLK_W + lg_or_zero(l2_sets_p) + lg_or_zero(num_cce_p)
                           + lg_or_zero(l2_slices_p) + lg_or_zero(l2_banks_p);

    typedef struct packed {
        logic [daddr_width_p-1:0] addr;
        logic [CH_W-1:0]          ch;
        logic [tag_p-1:0]         tag;
    } entry_t;

    logic [daddr_width_p-1:0] xl_addr;
    logic [daddr_width_p-1:0] xl_lin;
    logic [CH_W-1:0]          xl_ch;
    entry_t                   enq_ent;
    logic                     enq;
    logic                     deq;

    entry_t      mem_q [2];
    entry_t      mem_d [2];
    logic        wptr_q, wptr_d;
    logic        rptr_q, rptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] count_q, count_d;

    bp_me_dram_hash_swizzle #(
        .daddr_width_p    (daddr_width_p),
        .l2_block_width_p (l2_block_width_p),
        .l2_sets_p        (l2_sets_p),
        .num_cce_p        (num_cce_p),
        .l2_slices_p      (l2_slices_p),
        .l2_banks_p       (l2_banks_p)
    ) u_swizzle (
        .addr_i (addr_i),
        .mode_i (mode_i),
        .addr_o (xl_addr),
        .lin_o  (xl_lin)
    );

    // Channel from linear block-adjacent bits, optionally folded with tag bits.
    always_comb begin
        int idx;
        xl_ch = '0;
        idx   = 0;
        for (int i = 0; i < LG_CH; i++) begin
            xl_ch[i] = xl_lin[BLK_W+i];
            idx      = TAG_OFF + i;
            if (xor_hash_p != 0 && idx < daddr_width_p)
                xl_ch[i] = xl_ch[i] ^ xl_lin[idx];
        end
    end

    // Handshakes and next-state for FIFO, error flag and counter.
    always_comb begin
        ready_and_o = ~reset_i & (cnt_q != 2'd2);
        v_o         = ~reset_i & (cnt_q != 2'd0);
        enq         = v_i & ready_and_o;
        deq         = v_o & ready_and_i;
        enq_ent     = '{addr: xl_addr, ch: xl_ch, tag: tag_i};
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        if (enq) begin
            mem_d[wptr_q] = enq_ent;
            wptr_d        = ~wptr_q;
        end
        if (deq)
            rptr_d = ~rptr_q;
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        err_d   = err_q | (enq & (mode_i == 2'b11));
        count_d = count_q + {31'd0, deq};
    end

    // Control state with synchronous reset; reset drops all entries.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            cnt_q   <= 2'd0;
            err_q   <= 1'b0;
            count_q <= 32'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are qualified by occupancy so need no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign addr_o    = mem_q[rptr_q].addr;
    assign channel_o = mem_q[rptr_q].ch;
    assign tag_o     = mem_q[rptr_q].tag;
    assign err_o     = err_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_bp_me_dram_hash_xlate.sv
// Directed bench for the DRAM hash translator.
// A second instance with XOR folding covers the hashed channel path.
module tb_bp_me_dram_hash_xlate;

    localparam logic [1:0] BYP = 2'b00;
    localparam logic [1:0] DEC = 2'b01;
    localparam logic [1:0] ENC = 2'b10;
    localparam logic [1:0] RSV = 2'b11;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [15:0] addr_i;
    logic [1:0]  mode_i;
    logic [0:0]  tag_i;
    logic        v_i;
    logic        ready_and_i;

    logic        ready_and_o;
    logic [15:0] addr_o;
    logic [0:0]  channel_o;
    logic [0:0]  tag_o;
    logic        v_o;
    logic        err_o;
    logic [31:0] count_o;

    logic        x_ready;
    logic [15:0] x_addr;
    logic [0:0]  x_ch;
    logic [0:0]  x_tag;
    logic        x_v;
    logic        x_err;
    logic [31:0] x_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] x;
    logic [15:0] y;

    always #5 clk_i = ~clk_i;

    bp_me_dram_hash_xlate #(.xor_hash_p(0)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .addr_i      (addr_i),
        .mode_i      (mode_i),
        .tag_i       (tag_i),
        .v_i         (v_i),
        .ready_and_o (ready_and_o),
        .addr_o      (addr_o),
        .channel_o   (channel_o),
        .tag_o       (tag_o),
        .v_o         (v_o),
        .ready_and_i (ready_and_i),
        .err_o       (err_o),
        .count_o     (count_o)
    );

    bp_me_dram_hash_xlate #(.xor_hash_p(1)) dut_x (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .addr_i      (addr_i),
        .mode_i      (mode_i),
        .tag_i       (tag_i),
        .v_i         (v_i),
        .ready_and_o (x_ready),
        .addr_o      (x_addr),
        .channel_o   (x_ch),
        .tag_o       (x_tag),
        .v_o         (x_v),
        .ready_and_i (ready_and_i),
        .err_o       (x_err),
        .count_o     (x_count)
    );

    task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tg, got, exp);
        end
    endtask

    // Drive one request from a negedge; returns at the next negedge.
    task automatic send(input logic [1:0] m, input logic [15:0] a, input logic t);
        mode_i = m;
        addr_i = a;
        tag_i  = t;
        v_i    = 1'b1;
        @(posedge clk_i);
        #1 v_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        reset_i     = 1'b1;
        v_i         = 1'b0;
        mode_i      = BYP;
        addr_i      = '0;
        tag_i       = '0;
        ready_and_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_rdy_held", ready_and_o, 0);
        chk("rst_v", v_o, 0);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_rdy", ready_and_o, 1);
        chk("post_rst_v", v_o, 0);
        chk("post_rst_err", err_o, 0);
        chk("post_rst_cnt", count_o, 0);

        send(DEC, 16'h0040, 1'b1);
        chk("dec40_v", v_o, 1);
        chk("dec40_addr", addr_o, 16'h0200);
        chk("dec40_tag", tag_o, 1);
        send(DEC, 16'h0100, 1'b0);
        chk("dec100_v", v_o, 1);
        chk("dec100_addr", addr_o, 16'h0040);
        chk("dec100_ch", channel_o, 1);
        chk("dec100_tag", tag_o, 0);
        chk("dec100_xch", x_ch, 1);
        send(DEC, 16'h0900, 1'b1);
        chk("dec900_addr", addr_o, 16'h0840);
        chk("dec900_ch", channel_o, 1);
        chk("dec900_xch", x_ch, 0);
        send(ENC, 16'h0200, 1'b0);
        chk("enc200_addr", addr_o, 16'h0040);
        chk("enc200_ch", channel_o, 0);
        send(ENC, 16'h0040, 1'b0);
        chk("enc40_addr", addr_o, 16'h0100);
        chk("enc40_ch", channel_o, 1);
        send(BYP, 16'hABCD, 1'b1);
        chk("byp_addr", addr_o, 16'hABCD);
        chk("byp_ch", channel_o, 1);
        chk("byp_xch", x_ch, 0);
        chk("byp_err", err_o, 0);
        @(negedge clk_i);
        chk("drain_v", v_o, 0);
        chk("cnt6", count_o, 6);

        for (int i = 0; i < 256; i++) begin
            x = 16'($urandom_range(0, 65535));
            send(ENC, x, 1'b0);
            y = addr_o;
            send(DEC, y, 1'b0);
            chk("roundtrip", addr_o, x);
        end
        @(negedge clk_i);
        chk("cnt518", count_o, 518);

        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst2_cnt", count_o, 0);

        ready_and_i = 1'b0;
        mode_i      = DEC;
        tag_i       = 1'b0;
        addr_i      = 16'h0040;
        v_i         = 1'b1;
        @(posedge clk_i);
        #1 chk("bp_rdy1", ready_and_o, 1);
        addr_i = 16'h0100;
        @(posedge clk_i);
        #1 addr_i = 16'h0900;
        @(negedge clk_i);
        chk("bp_full_rdy", ready_and_o, 0);
        chk("bp_v", v_o, 1);
        chk("bp_head", addr_o, 16'h0200);
        @(negedge clk_i);
        chk("bp_stable", addr_o, 16'h0200);
        chk("bp_still_full", ready_and_o, 0);
        v_i         = 1'b0;
        ready_and_i = 1'b1;
        @(negedge clk_i);
        chk("bp_2nd_v", v_o, 1);
        chk("bp_2nd", addr_o, 16'h0040);
        chk("bp_rdy_back", ready_and_o, 1);
        @(negedge clk_i);
        chk("bp_empty", v_o, 0);
        chk("bp_cnt2", count_o, 2);

        chk("rsv_err_pre", err_o, 0);
        send(RSV, 16'h1234, 1'b0);
        chk("rsv_addr", addr_o, 16'h1234);
        chk("rsv_err", err_o, 1);
        repeat (2) @(negedge clk_i);
        chk("rsv_sticky", err_o, 1);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rsv_err_clr", err_o, 0);

        ready_and_i = 1'b0;
        send(DEC, 16'h0040, 1'b0);
        send(DEC, 16'h0100, 1'b0);
        chk("mid_full", ready_and_o, 0);
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("mid_v", v_o, 0);
        chk("mid_cnt", count_o, 0);
        reset_i     = 1'b0;
        ready_and_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rdy", ready_and_o, 1);
        chk("mid_v_after", v_o, 0);
        repeat (3) @(negedge clk_i);
        chk("mid_no_stale", v_o, 0);
        chk("mid_cnt_after", count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
